fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 8: byte width of FIFO data and output stream.
REQ-002 Parameter CNT_W, default 16: width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  1 = reader may pop the FIFO; 0 = no new pops, the buffer still drains.
REQ-006 flush  input  1  synchronous; discards buffered words for one cycle.
REQ-007 fifo_empty  input  1  FIFO has no readable word.
REQ-008 fifo_data  input  DATA_W  show-ahead FIFO head word, valid in the same cycle whenever fifo_empty=0.
REQ-009 fifo_rd_en  output  1  combinational pop strobe; FIFO advances its read pointer at this clock edge.
REQ-010 m_data  output  DATA_W  output stream data.
REQ-011 m_valid  output  1  m_data holds a valid word.
REQ-012 m_ready  input  1  downstream accepts the word when m_valid=1 and m_ready=1.
REQ-013 rd_count  output  CNT_W  number of words delivered downstream since reset.
REQ-014 busy  output  1  1 when the buffer holds at least one word.

Function
REQ-015 The reader SHALL keep a 2-entry output buffer, with a head entry driving m_data and a tail entry.
REQ-016 The buffer occupancy state machine SHALL have three states: EMPTY, ONE and TWO.
REQ-017 Pop condition: fifo_rd_en SHALL be 1 exactly when en=1, fifo_empty=0, flush=0, and either the state is not TWO or the state is TWO with m_ready=1.
REQ-018 When a pop occurs, the reader SHALL capture fifo_data in the same cycle (zero-latency capture).
REQ-019 The captured word SHALL go to the first free slot after any same-cycle dequeue.
REQ-020 m_valid SHALL be 1 in states ONE and TWO, and m_data SHALL equal the head entry.
REQ-021 Transitions SHALL follow these rules (pop=P, accept=A=m_valid&m_ready):
  - EMPTY: P→ONE, else EMPTY.
  - ONE: P&!A→TWO; P&A→ONE with the new word as head; !P&A→EMPTY; else ONE.
  - TWO: A→ONE, or A&P→TWO with tail promoted and the new word as tail; else TWO.
REQ-022 Word order SHALL be preserved: the output order equals the pop order, with no duplication or loss.
REQ-023 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 Throughput: with the FIFO non-empty and m_ready held at 1, the reader SHALL deliver one word per cycle after the first pop.
REQ-025 First-word latency SHALL be one cycle: pop at edge N gives m_valid=1 after edge N.
REQ-026 rd_count SHALL increment by 1 on each accept and wrap modulo 2^CNT_W with no saturation.
REQ-027 flush=1 SHALL force the next state to EMPTY and suppress fifo_rd_en in that cycle.
REQ-028 A handshake that completes in a flush cycle SHALL still increment rd_count.
REQ-029 The reader SHALL never assert fifo_rd_en while fifo_empty=1 (underflow protection).
REQ-030 en falling mid-stream SHALL stop pops immediately without corrupting words already buffered.

Reset
REQ-031 rstn=0 SHALL asynchronously force the state to EMPTY, m_valid=0, m_data=0, rd_count=0, busy=0 and both buffer entries to 0.
REQ-032 fifo_rd_en SHALL be 0 while rstn=0, regardless of the other inputs.
REQ-033 Reset mid-operation SHALL discard buffered words, and the first pop after release SHALL behave exactly as from EMPTY.

Structure
REQ-034 A shared package fifo_reader_pkg SHALL hold the state enumeration (EMPTY/ONE/TWO) and the default DATA_W and CNT_W constants.
REQ-035 The 2-entry buffer SHALL be a single sub-module named skid_buf2, and the pop logic and counter SHALL stay in the top level.

Verification
REQ-036 The bench SHALL cover these scenarios:
  - Reset then idle, fifo_empty=1 → fifo_rd_en=0, m_valid=0 and rd_count=0 for 10 cycles.
  - FIFO preloaded with 0x01..0x20, m_ready=1, en=1 → m_data sequence 0x01..0x20, one word per cycle, rd_count=32, exactly 32 pops.
  - FIFO holds 0xA5,0x5A,0x3C and m_ready=0 for 5 cycles → exactly 2 pops with busy=1 and m_data held at 0xA5; on m_ready=1, output is 0xA5,0x5A,0x3C.
  - State TWO, then flush=1 for one cycle → m_valid=0 next cycle, no pop in the flush cycle, and the next word popped appears as head.
  - Random m_ready, en and fifo_empty over 10k cycles → no pop while fifo_empty=1, order preserved against a scoreboard, and rd_count equals accepted words mod 2^16.
  - rstn pulsed low in state TWO → all outputs 0 immediately, and after release a single pop of 0x77 gives m_data=0x77, m_valid=1.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// fifo_reader_pkg
// Shared definitions for the FIFO reader: buffer occupancy states, default
// widths, and the pop-permission helper used by the top level.
// ---------------------------------------------------------------------------
package fifo_reader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // The buffer has room for a new word unless it is full; when full, room
    // only appears if the head is leaving in the same cycle.
    function automatic logic has_room(input state_e state, input logic m_ready);
        return (state != TWO) || m_ready;
    endfunction

endpackage : fifo_reader_pkg

// File: rtl/fifo_reader_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
// Two-entry output buffer (head + tail) with occupancy state machine.
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : empties the buffer at the next edge
//   push       : write push_data into the first free slot after any dequeue
//   push_data  : word to store
//   accept     : head word is consumed this cycle (valid & ready)
//   head       : current head word (output stream data)
//   state      : occupancy (EMPTY / ONE / TWO)
//   valid      : buffer holds at least one word
// ---------------------------------------------------------------------------
module skid_buf2
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              accept,
    output logic [DATA_W-1:0] head,
    output state_e            state,
    output logic              valid
);

    state_e            state_d, state_q;
    logic [DATA_W-1:0] head_d, head_q;
    logic [DATA_W-1:0] tail_d, tail_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({push, accept})
                    2'b10: begin
                        tail_d  = push_data;
                        state_d = TWO;
                    end
                    // Head leaves while a new word arrives: new word becomes head.
                    2'b11: head_d = push_data;
                    2'b01: state_d = EMPTY;
                    default: state_d = ONE;
                endcase
            end
            TWO: begin
                if (accept) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any transition; stored words are simply abandoned.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    assign head  = head_q;
    assign state = state_q;
    assign valid = (state_q != EMPTY);

endmodule : skid_buf2

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
// Pops a show-ahead FIFO into a 2-entry output buffer and presents the words
// as a valid/ready stream, counting delivered words.
//   clk, rstn   : clock, asynchronous active-low reset
//   en          : allow new pops (buffered words still drain when 0)
//   flush       : discard buffered words; no pop in this cycle
//   fifo_empty  : FIFO has no readable word
//   fifo_data   : FIFO head word (show-ahead)
//   fifo_rd_en  : combinational pop strobe
//   m_data      : output stream data
//   m_valid     : m_data is valid
//   m_ready     : downstream ready
//   rd_count    : words accepted downstream since reset (wraps)
//   busy        : buffer holds at least one word
// ---------------------------------------------------------------------------
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy
);

    state_e           buf_state;
    logic             buf_valid;
    logic             accept;
    logic [CNT_W-1:0] rd_count_d, rd_count_q;

    assign accept = buf_valid & m_ready;

    // rstn is part of the strobe so the FIFO is never popped while the
    // reader is held in reset, whatever the other inputs do.
    always_comb begin
        fifo_rd_en = rstn & en & ~fifo_empty & ~flush & has_room(buf_state, m_ready);
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (fifo_rd_en),
        .push_data (fifo_data),
        .accept    (accept),
        .head      (m_data),
        .state     (buf_state),
        .valid     (buf_valid)
    );

    // Handshakes completing in a flush cycle are still counted.
    always_comb begin
        rd_count_d = rd_count_q;
        if (accept) begin
            rd_count_d = rd_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign m_valid  = buf_valid;
    assign busy     = buf_valid;
    assign rd_count = rd_count_q;

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
// Self-checking bench: a queue-based FIFO model feeds the DUT and a queue of
// at most two words stands in for the output buffer.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        flush;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] rd_count;
    logic        busy;

    logic        stall;
    logic [7:0]  fifo_q[$];
    logic [7:0]  mdl[$];
    int unsigned cnt;
    int          pops;
    int          errors;
    int          checks;

    fifo_reader #(
        .DATA_W (8),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock cycle: present FIFO view, check at the falling edge, update the
    // reference model, and return 1 time unit after the rising edge.
    task automatic step();
        logic exp_pop;
        logic acc;
        @(negedge clk);
        fifo_empty = (fifo_q.size() == 0) || stall;
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
        #1;
        exp_pop = rstn && en && !fifo_empty && !flush && (mdl.size() < 2 || m_ready);
        check("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_pop});
        check("no_underflow", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
        check("m_valid", {31'd0, m_valid}, {31'd0, mdl.size() > 0});
        check("busy", {31'd0, busy}, {31'd0, mdl.size() > 0});
        if (mdl.size() > 0) check("m_data", {24'd0, m_data}, {24'd0, mdl[0]});
        check("rd_count", {16'd0, rd_count}, cnt & 32'hFFFF);
        acc = (mdl.size() > 0) && m_ready;
        if (acc) begin
            void'(mdl.pop_front());
            cnt++;
        end
        if (flush) begin
            mdl.delete();
        end else if (exp_pop) begin
            mdl.push_back(fifo_q.pop_front());
            pops++;
        end
        @(posedge clk);
        #1;
        if (!rstn) begin
            mdl.delete();
            cnt = 0;
        end
    endtask

    initial begin
        errors = 0; checks = 0; cnt = 0; pops = 0;
        rstn = 1'b0; en = 1'b1; flush = 1'b0; m_ready = 1'b1; stall = 1'b0;
        fifo_empty = 1'b1; fifo_data = 8'h00;

        // Reset held with a non-empty FIFO and en=1: no pop, outputs zero.
        fifo_q.push_back(8'h99);
        repeat (3) step();
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_count", {16'd0, rd_count}, 32'd0);
        fifo_q.delete();
        rstn = 1'b1;

        // Idle with empty FIFO.
        repeat (10) step();
        check("idle_count", {16'd0, rd_count}, 32'd0);

        // Streaming 0x01..0x20 at full rate.
        pops = 0;
        for (int i = 1; i <= 32; i++) fifo_q.push_back(8'(i));
        repeat (36) step();
        check("stream_pops", pops, 32);
        check("stream_count", {16'd0, rd_count}, 32'd32);

        // Back-pressure: only two words fit while m_ready=0.
        pops = 0;
        m_ready = 1'b0;
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A); fifo_q.push_back(8'h3C);
        repeat (5) step();
        check("bp_pops", pops, 2);
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_hold", {24'd0, m_data}, 32'hA5);
        m_ready = 1'b1;
        repeat (5) step();
        check("bp_count", {16'd0, rd_count}, 32'd35);

        // Flush from state TWO.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hB0 + 8'(i));
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b1;
        step();
        check("flush_head_v", {31'd0, m_valid}, 32'd1);
        check("flush_head", {24'd0, m_data}, 32'hB2);
        repeat (4) step();

        // Randomized traffic.
        for (int c = 0; c < 10000; c++) begin
            if (fifo_q.size() < 4 && $urandom_range(1, 0) == 1) fifo_q.push_back(8'($urandom));
            en      = ($urandom_range(3, 0) != 0);
            m_ready = $urandom_range(1, 0) == 1;
            stall   = ($urandom_range(3, 0) == 0);
            flush   = ($urandom_range(63, 0) == 0);
            step();
        end
        flush = 1'b0; stall = 1'b0; en = 1'b1;
        check("rnd_count", {16'd0, rd_count}, cnt & 32'hFFFF);

        // Asynchronous reset in state TWO.
        fifo_q.delete();
        m_ready = 1'b0;
        fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2); fifo_q.push_back(8'hC3);
        repeat (2) step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("arst_valid", {31'd0, m_valid}, 32'd0);
        check("arst_data", {24'd0, m_data}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_count", {16'd0, rd_count}, 32'd0);
        check("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        mdl.delete();
        cnt = 0;
        step();
        fifo_q.delete();
        rstn = 1'b1;
        fifo_q.push_back(8'h77);
        step();
        check("post_rst_data", {24'd0, m_data}, 32'h77);
        check("post_rst_valid", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_reader
